// File: rtl/maxpool_stream.sv
// Streaming 2x2/stride-2 signed max-pool over a raster-ordered FM_SIZE x FM_SIZE map.
// Optional fused ReLU on the pooled output when MAXP_RELU_EN is defined.
`ifndef DW
`define DW 8
`endif

module maxpool_stream #(
  parameter int FM_SIZE = 4,
  parameter int DW      = `DW
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_en,
  input  logic signed [DW-1:0] i_data,
  output logic                 o_en,
  output logic signed [DW-1:0] o_data,
  output logic                 o_frame_done
);

  localparam int CW = (FM_SIZE > 1) ? $clog2(FM_SIZE) : 1;
  localparam int P  = FM_SIZE / 2;
  localparam int IW = (P > 1) ? $clog2(P) : 1;

  localparam logic [CW-1:0] LAST_IDX  = CW'(FM_SIZE - 1);
  localparam logic [CW-1:0] LAST_POOL = CW'(2 * P - 1);

  logic [CW-1:0]        col, row;
  logic signed [DW-1:0] hold;
  logic signed [DW-1:0] linebuf [P];

  logic [IW-1:0]        lb_idx;
  logic signed [DW-1:0] max2, max3, pooled;
  logic                 in_pool;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    lb_idx  = IW'(col >> 1);
    max2    = (hold > i_data) ? hold : i_data;
    max3    = (linebuf[lb_idx] > max2) ? linebuf[lb_idx] : max2;
    in_pool = (col <= LAST_POOL) && (row <= LAST_POOL);
`ifdef MAXP_RELU_EN
    pooled  = max3[DW-1] ? '0 : max3;
`else
    pooled  = max3;
`endif
  end

  // NOTE: state uses non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col          <= '0;
      row          <= '0;
      hold         <= '0;
      o_en         <= 1'b0;
      o_data       <= '0;
      o_frame_done <= 1'b0;
      // NOTE: the line buffer is small register storage, so it can be reset alongside the counters.
      for (int i = 0; i < P; i++) linebuf[i] <= '0;
    end else begin
      o_en         <= 1'b0;
      o_frame_done <= 1'b0;
      if (i_clear) begin
        col  <= '0;
        row  <= '0;
        hold <= '0;
      end else if (i_en) begin
        if (col == LAST_IDX) begin
          col <= '0;
          row <= (row == LAST_IDX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end

        // Words in a dropped odd last row/column are counted above but never pooled.
        if (in_pool) begin
          if (!col[0]) begin
            hold <= i_data;
          end else if (!row[0]) begin
            linebuf[lb_idx] <= max2;
          end else begin
            o_data       <= pooled;
            o_en         <= 1'b1;
            o_frame_done <= (row == LAST_POOL) && (col == LAST_POOL);
          end
        end
      end
    end
  end

endmodule
